// File: rtl/rope_pkg.sv
// rtl/rope_pkg.sv - shared types and constants for the rope rider
package rope_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        HANG = 2'd1,
        DROP = 2'd2
    } rope_state_e;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [11:0] coord_ext_t;

    localparam int HAND_OFF    = 8;
    localparam int HANG_Y      = 4;
    localparam int GRAB_TOL    = 8;
    localparam int STEP        = 2;
    localparam int FALL_FRAMES = 15;
    localparam int CNT_W       = $clog2(FALL_FRAMES);

    localparam coord_ext_t HAND_OFF_X = coord_ext_t'(HAND_OFF);
    localparam coord_ext_t HANG_Y_X   = coord_ext_t'(HANG_Y);
    localparam coord_ext_t GRAB_TOL_X = coord_ext_t'(GRAB_TOL);
    localparam coord_ext_t STEP_X     = coord_ext_t'(STEP);
    localparam coord_ext_t ZERO_X     = 12'sd0;
    localparam coord_ext_t ONE_X      = 12'sd1;

    function automatic coord_ext_t ext(input coord_t c);
        return {c[10], c};
    endfunction

endpackage

// File: rtl/rope_rider_if.sv
// rtl/rope_rider_if.sv - rope/player/key inputs and resolved player outputs
interface rope_rider_if;
    logic            startOfFrame;
    rope_pkg::coord_t ropeTopLeftX;
    rope_pkg::coord_t ropeTopLeftY;
    rope_pkg::coord_t ropeWidthX;
    rope_pkg::coord_t playerInX;
    rope_pkg::coord_t playerInY;
    logic            keyUp;
    logic            keyDown;
    logic            keyLeft;
    logic            keyRight;
    rope_pkg::coord_t playerX;
    rope_pkg::coord_t playerY;
    logic            attached;
    logic            falling;
    logic            grabPulse;

    modport master (
        output startOfFrame, ropeTopLeftX, ropeTopLeftY, ropeWidthX,
        output playerInX, playerInY, keyUp, keyDown, keyLeft, keyRight,
        input  playerX, playerY, attached, falling, grabPulse
    );

    modport slave (
        input  startOfFrame, ropeTopLeftX, ropeTopLeftY, ropeWidthX,
        input  playerInX, playerInY, keyUp, keyDown, keyLeft, keyRight,
        output playerX, playerY, attached, falling, grabPulse
    );
endinterface

// File: rtl/rope_grab_window.sv
// rtl/rope_grab_window.sv - hand point / player Y versus rope box compare
module rope_grab_window
    import rope_pkg::*;
(
    input  coord_ext_t hand_x,
    input  coord_t     player_in_y,
    input  coord_t     rope_x,
    input  coord_t     rope_y,
    input  coord_t     rope_w,
    output logic       can_grab,
    output coord_ext_t raw_off
);

    coord_ext_t rx;
    coord_ext_t ry;
    coord_ext_t py;
    coord_ext_t right_edge;

    always_comb begin
        rx         = ext(rope_x);
        ry         = ext(rope_y);
        py         = ext(player_in_y);
        right_edge = rx + ext(rope_w) - ONE_X;
        raw_off    = hand_x - rx;
        can_grab   = (py >= ry) && (py <= ry + GRAB_TOL_X) &&
                     (hand_x >= rx) && (hand_x <= right_edge);
    end

endmodule

// File: rtl/rope_rider.sv
// rtl/rope_rider.sv - grabs, carries, shimmies and drops the player on the rope
module rope_rider
    import rope_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    rope_rider_if.slave  bus
);

    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_FRAMES - 1);

    rope_state_e      state_q, state_d;
    coord_ext_t       off_q, off_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    coord_t           player_x_q, player_x_d;
    coord_t           player_y_q, player_y_d;
    logic             attached_q, attached_d;
    logic             falling_q, falling_d;
    logic             grab_q, grab_d;

    coord_ext_t hand_x;
    coord_ext_t w_max;
    coord_ext_t off_shim;
    logic       can_grab;
    coord_ext_t raw_off;

    assign hand_x = ext(bus.playerInX) + HAND_OFF_X;
    assign w_max  = ext(bus.ropeWidthX) - ONE_X;

    rope_grab_window u_window (
        .hand_x      (hand_x),
        .player_in_y (bus.playerInY),
        .rope_x      (bus.ropeTopLeftX),
        .rope_y      (bus.ropeTopLeftY),
        .rope_w      (bus.ropeWidthX),
        .can_grab    (can_grab),
        .raw_off     (raw_off)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FREE;
            off_q      <= ZERO_X;
            fall_cnt_q <= '0;
            player_x_q <= bus.playerInX;
            player_y_q <= bus.playerInY;
            attached_q <= 1'b0;
            falling_q  <= 1'b0;
            grab_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            fall_cnt_q <= fall_cnt_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            attached_q <= attached_d;
            falling_q  <= falling_d;
            grab_q     <= grab_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        fall_cnt_d = fall_cnt_q;
        off_shim   = off_q;
        case (state_q)
            FREE: begin
                if (bus.startOfFrame && bus.keyUp && can_grab) begin
                    state_d = HANG;
                    off_d   = raw_off;
                end
            end
            HANG: begin
                if (bus.startOfFrame) begin
                    if (bus.keyDown) begin
                        state_d    = DROP;
                        fall_cnt_d = '0;
                    end else begin
                        if (bus.keyLeft && !bus.keyRight) begin
                            off_shim = (off_q - STEP_X < ZERO_X) ? ZERO_X : off_q - STEP_X;
                        end else if (bus.keyRight && !bus.keyLeft) begin
                            off_shim = (off_q + STEP_X > w_max) ? w_max : off_q + STEP_X;
                        end
                        // A shrinking rope pushes the hanging player inward from its right end.
                        off_d = (off_shim > w_max) ? w_max : off_shim;
                    end
                end
            end
            DROP: begin
                if (bus.startOfFrame) begin
                    if (fall_cnt_q == FALL_LAST) begin
                        state_d    = FREE;
                        fall_cnt_d = '0;
                    end else begin
                        fall_cnt_d = fall_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        player_x_d = bus.playerInX;
        player_y_d = bus.playerInY;
        attached_d = (state_d == HANG);
        falling_d  = (state_d == DROP);
        grab_d     = (state_q == FREE) && (state_d == HANG);
        if (state_d == HANG) begin
            player_x_d = coord_t'(ext(bus.ropeTopLeftX) + off_d - HAND_OFF_X);
            player_y_d = coord_t'(ext(bus.ropeTopLeftY) + HANG_Y_X);
        end
    end

    assign bus.playerX   = player_x_q;
    assign bus.playerY   = player_y_q;
    assign bus.attached  = attached_q;
    assign bus.falling   = falling_q;
    assign bus.grabPulse = grab_q;

endmodule

// File: tb/tb_rope_rider.sv
// tb/tb_rope_rider.sv - directed self-checking bench for rope_rider
module tb_rope_rider;
    import rope_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rope_rider_if ifc ();

    rope_rider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic sof);
        ifc.startOfFrame = sof;
        @(posedge clk);
        #1;
        ifc.startOfFrame = 1'b0;
    endtask

    task automatic set_rope(input int x, input int y, input int w);
        ifc.ropeTopLeftX = coord_t'(x);
        ifc.ropeTopLeftY = coord_t'(y);
        ifc.ropeWidthX   = coord_t'(w);
    endtask

    task automatic set_player(input int x, input int y);
        ifc.playerInX = coord_t'(x);
        ifc.playerInY = coord_t'(y);
    endtask

    task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
        ifc.keyUp    = u;
        ifc.keyDown  = d;
        ifc.keyLeft  = l;
        ifc.keyRight = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifc.startOfFrame = 1'b0;
        set_keys(0, 0, 0, 0);
        set_rope(450, 226, 123);
        set_player(480, 230);
        tick(1'b0);
        tick(1'b0);
        chk("rst_attached", int'(ifc.attached), 0);
        chk("rst_falling", int'(ifc.falling), 0);
        chk("rst_grab", int'(ifc.grabPulse), 0);
        chk("rst_px", int'(ifc.playerX), 480);
        chk("rst_py", int'(ifc.playerY), 230);
        reset = 1'b0;

        // grab: handX=488, off=38
        set_keys(1, 0, 0, 0);
        tick(1'b1);
        chk("grab_attached", int'(ifc.attached), 1);
        chk("grab_pulse", int'(ifc.grabPulse), 1);
        chk("grab_px", int'(ifc.playerX), 480);
        chk("grab_py", int'(ifc.playerY), 230);
        set_keys(0, 0, 0, 0);
        tick(1'b0);
        chk("grab_pulse_end", int'(ifc.grabPulse), 0);
        chk("grab_hold", int'(ifc.attached), 1);

        // ride
        set_rope(455, 226, 123);
        tick(1'b1);
        chk("ride_px", int'(ifc.playerX), 485);

        // shimmy left to 0
        set_keys(0, 0, 1, 0);
        repeat (25) tick(1'b1);
        chk("left_sat_px", int'(ifc.playerX), 447);
        set_keys(0, 0, 1, 1);
        tick(1'b1);
        chk("both_keys_px", int'(ifc.playerX), 447);

        // shimmy right to 122
        set_rope(450, 226, 123);
        set_keys(0, 0, 0, 1);
        repeat (70) tick(1'b1);
        chk("right_sat_px", int'(ifc.playerX), 564);
        set_keys(0, 0, 0, 0);

        // shrink push
        set_rope(460, 226, 113);
        tick(1'b0);
        chk("shrink_nosof_px", int'(ifc.playerX), 574);
        tick(1'b1);
        chk("shrink_px", int'(ifc.playerX), 564);
        chk("shrink_py", int'(ifc.playerY), 230);

        // drop
        set_keys(0, 1, 0, 0);
        tick(1'b1);
        chk("drop_falling", int'(ifc.falling), 1);
        chk("drop_attached", int'(ifc.attached), 0);
        chk("drop_px", int'(ifc.playerX), 480);
        chk("drop_py", int'(ifc.playerY), 230);
        set_keys(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tick(1'b1);
            chk("drop_no_regrab", int'(ifc.attached), 0);
        end
        chk("drop_still_falling", int'(ifc.falling), 1);
        tick(1'b1);
        chk("drop_done_falling", int'(ifc.falling), 0);
        chk("drop_done_attached", int'(ifc.attached), 0);
        tick(1'b1);
        chk("regrab_after_free", int'(ifc.attached), 1);

        // reset mid-HANG without SOF
        set_keys(0, 0, 0, 0);
        reset = 1'b1;
        tick(1'b0);
        chk("rst_hang_attached", int'(ifc.attached), 0);
        chk("rst_hang_px", int'(ifc.playerX), 480);
        reset = 1'b0;
        tick(1'b1);
        chk("rst_hang_stays_free", int'(ifc.attached), 0);

        // vertical window: ropeY=227 -> [227,235]
        set_rope(450, 227, 123);
        set_keys(1, 0, 0, 0);
        set_player(480, 235);
        tick(1'b1);
        chk("win_y_top_grab", int'(ifc.attached), 1);
        chk("win_y_top_py", int'(ifc.playerY), 231);
        do_reset();
        set_player(480, 236);
        tick(1'b1);
        chk("win_y_over_miss", int'(ifc.attached), 0);
        set_player(480, 225);
        tick(1'b1);
        chk("win_y_under_miss", int'(ifc.attached), 0);
        chk("win_y_under_pulse", int'(ifc.grabPulse), 0);

        // horizontal window: right edge = 572
        set_rope(450, 226, 123);
        set_player(564, 230);
        tick(1'b1);
        chk("win_x_edge_grab", int'(ifc.attached), 1);
        chk("win_x_edge_px", int'(ifc.playerX), 564);
        do_reset();
        set_player(565, 230);
        tick(1'b1);
        chk("win_x_over_miss", int'(ifc.attached), 0);
        set_player(441, 230);
        tick(1'b1);
        chk("win_x_left_miss", int'(ifc.attached), 0);
        set_player(442, 230);
        tick(1'b1);
        chk("win_x_left_grab", int'(ifc.attached), 1);
        chk("win_x_left_px", int'(ifc.playerX), 442);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
